// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 size codes, FSM states, byte-enable constants and alignment check for the LSU
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    // Unknown funct3 codes are reported as misaligned so they never reach the bus.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
        return (size == F3_LB || size == F3_LBU) ? 1'b1 :
               (size == F3_LH || size == F3_LHU) ? !lo[0] :
               (size == F3_LW)                   ? (lo == 2'b00) : 1'b0;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/strobes and load byte/half selection with sign or zero extension
// Ports: i_size (funct3), i_addr_lo (addr[1:0]), i_we (store), i_wdata (low-aligned store data),
//        i_rdata (bus word) -> o_wdata (steered), o_be (strobes), o_rdata (extended load result)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_rdata >> {i_addr_lo, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_wdata = (i_size[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
                  (i_size[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
        o_be    = !i_we                  ? BE_ALL :
                  (i_size == F3_SB)      ? (BE_B0 << i_addr_lo) :
                  (i_size == F3_SH)      ? (i_addr_lo[1] ? BE_HI : BE_LO) : BE_ALL;
        o_rdata = (i_size == F3_LB)  ? {{24{w_byte[7]}}, w_byte} :
                  (i_size == F3_LH)  ? {{16{w_half[15]}}, w_half} :
                  (i_size == F3_LBU) ? {24'd0, w_byte} :
                  (i_size == F3_LHU) ? {16'd0, w_half} : i_rdata;
    end
endmodule

// File: rtl/lsu.sv
// lsu: RV32I memory-access stage; bus initiator with stall, lane steering, load extension, timeout
// Ports: ex_mem request (req_valid_i, mem_*_i, rd_*_i), data bus (bus_*), registered write-back
//        (rd_*_o), stall (hold_flag_o), error pulses (misalign_o, bus_err_o)
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [2:0]        mem_size_i,
    input  logic              mem_we_i,
    input  logic              mem_re_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_wen_i,
    input  logic [31:0]       rd_data_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [3:0]        bus_be_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_err_i,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_wen_o,
    output logic              hold_flag_o,
    output logic              misalign_o,
    output logic              bus_err_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, w_ldata;
    logic [2:0]  r_size;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [CW-1:0] r_cnt;
    logic        w_memop, w_ok, w_accept, w_done, w_to;

    lsu_align u_align (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_we      (r_we),
        .i_wdata   (r_wdata),
        .i_rdata   (bus_rdata_i),
        .o_wdata   (bus_wdata_o),
        .o_be      (bus_be_o),
        .o_rdata   (w_ldata)
    );

    always_comb begin
        w_memop  = req_valid_i & (mem_we_i | mem_re_i);
        w_ok     = is_aligned(mem_size_i, mem_addr_i[1:0]);
        w_accept = (r_state == S_IDLE) & w_memop & w_ok;
        // A response in the grant cycle completes the access without visiting WAIT.
        w_done   = ((r_state == S_REQ) & bus_gnt_i & bus_rvalid_i) | ((r_state == S_WAIT) & bus_rvalid_i);
        w_to     = (TIMEOUT_CYCLES != 0) & (r_state != S_IDLE) & !w_done & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        w_next   = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_REQ : S_IDLE;
            S_REQ:   w_next = (w_done | w_to) ? S_IDLE : bus_gnt_i ? S_WAIT : S_REQ;
            S_WAIT:  w_next = (w_done | w_to) ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
        hold_flag_o = w_accept | ((r_state != S_IDLE) & !w_done & !w_to);
        bus_req_o   = r_state == S_REQ;
        bus_we_o    = r_we;
        bus_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_IDLE || w_next == S_IDLE) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_addr  <= mem_addr_i;
                r_wdata <= mem_data_i;
                r_size  <= mem_size_i;
                r_we    <= mem_we_i;
                r_rd    <= rd_addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
            rd_wen_o   <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            misalign_o <= (r_state == S_IDLE) & w_memop & !w_ok;
            bus_err_o  <= w_to | (w_done & bus_err_i);
            rd_wen_o   <= 1'b0;
            if ((r_state == S_IDLE) & req_valid_i & !w_memop) begin
                rd_addr_o <= rd_addr_i;
                rd_data_o <= rd_data_i;
                rd_wen_o  <= rd_wen_i;
            end else if (w_done & !r_we & !bus_err_i) begin
                rd_addr_o <= r_rd;
                rd_data_o <= w_ldata;
                rd_wen_o  <= r_rd != 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for the lsu memory-access stage
module tb_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid_i, mem_we_i, mem_re_i, rd_wen_i;
    logic [31:0] mem_addr_i, mem_data_i, rd_data_i;
    logic [2:0]  mem_size_i;
    logic [4:0]  rd_addr_i;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o, hold_flag_o, misalign_o, bus_err_o;
    int n_chk = 0, n_fail = 0;

    lsu #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_size_i(mem_size_i), .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
        .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .rd_data_i(rd_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_i(bus_err_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
        .hold_flag_o(hold_flag_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid_i = 0; mem_we_i = 0; mem_re_i = 0; mem_size_i = 0;
        mem_addr_i = 0; mem_data_i = 0; rd_addr_i = 0; rd_wen_i = 0; rd_data_i = 0;
    endtask

    task automatic mem_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd);
        req_valid_i = 1; mem_we_i = we; mem_re_i = !we; mem_size_i = size;
        mem_addr_i = addr; mem_data_i = data; rd_addr_i = rd; rd_wen_i = !we;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        idle_in();
        req_valid_i = 1; rd_addr_i = rd; rd_wen_i = 1; rd_data_i = val;
    endtask

    initial begin
        int n;
        idle_in();
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
        tick(); tick();
        check("rst_wen", rd_wen_o, 0);
        check("rst_hold", hold_flag_o, 0);
        check("rst_req", bus_req_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_err", {misalign_o, bus_err_o}, 0);
        rst_n = 1;
        // non-memory op
        tick();
        alu_op(5, 32'h1234);
        #1 check("alu_hold", hold_flag_o, 0);
        tick();
        check("alu_data", rd_data_o, 32'h1234);
        check("alu_rd", rd_addr_o, 5);
        check("alu_wen", rd_wen_o, 1);
        idle_in();
        tick();
        check("alu_wen_drop", rd_wen_o, 0);
        // LB 0x103
        mem_req(0, 3'b000, 32'h103, 0, 7);
        #1 check("lb_hold_acc", hold_flag_o, 1);
        check("lb_req_acc", bus_req_o, 0);
        tick();
        idle_in(); bus_gnt_i = 1;
        #1 check("lb_req", bus_req_o, 1);
        check("lb_hold_req", hold_flag_o, 1);
        check("lb_addr", bus_addr_o, 32'h100);
        check("lb_be", bus_be_o, 4'hF);
        check("lb_we", bus_we_o, 0);
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h80FF_00AA;
        #1 check("lb_hold_done", hold_flag_o, 0);
        check("lb_req_wait", bus_req_o, 0);
        tick();
        bus_rvalid_i = 0;
        check("lb_data", rd_data_o, 32'hFFFF_FF80);
        check("lb_wen", rd_wen_o, 1);
        check("lb_rd", rd_addr_o, 7);
        // SH 0x202
        mem_req(1, 3'b001, 32'h202, 32'hDEAD_BEEF, 0);
        #1 check("sh_hold_acc", hold_flag_o, 1);
        tick();
        idle_in();
        #1 check("sh_req", bus_req_o, 1);
        check("sh_we", bus_we_o, 1);
        check("sh_be", bus_be_o, 4'b1100);
        check("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
        check("sh_addr", bus_addr_o, 32'h200);
        bus_gnt_i = 1; bus_rvalid_i = 1;
        #1 check("sh_hold_done", hold_flag_o, 0);
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 0;
        check("sh_wen", rd_wen_o, 0);
        check("sh_req_end", bus_req_o, 0);
        // SB 0x001: byte lane 1
        mem_req(1, 3'b000, 32'h001, 32'h0000_0034, 0);
        tick();
        idle_in();
        #1 check("sb_be", bus_be_o, 4'b0010);
        check("sb_wdata", bus_wdata_o, 32'h3434_3434);
        bus_gnt_i = 1; bus_rvalid_i = 1;
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 0;
        // LW 0x301 misaligned
        mem_req(0, 3'b010, 32'h301, 0, 6);
        #1 check("lw_mis_hold", hold_flag_o, 0);
        tick();
        check("lw_mis_pulse", misalign_o, 1);
        check("lw_mis_wen", rd_wen_o, 0);
        check("lw_mis_req", bus_req_o, 0);
        idle_in();
        tick();
        check("lw_mis_end", misalign_o, 0);
        check("lw_mis_req2", bus_req_o, 0);
        // LHU 0x400 with gnt delayed three cycles
        mem_req(0, 3'b101, 32'h400, 0, 9);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("lhu_req_wait", {bus_req_o, bus_addr_o[30:0]}, {1'b1, 31'h400});
            tick();
        end
        bus_gnt_i = 1;
        #1 check("lhu_req_gnt", {bus_req_o, bus_addr_o[30:0]}, {1'b1, 31'h400});
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_9ABC;
        #1 check("lhu_req_drop", bus_req_o, 0);
        tick();
        bus_rvalid_i = 0;
        check("lhu_data", rd_data_o, 32'h0000_9ABC);
        check("lhu_wen", rd_wen_o, 1);
        // LH 0x402 sign extension of upper half
        mem_req(0, 3'b001, 32'h402, 0, 10);
        tick();
        idle_in(); bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h9ABC_1234;
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 0;
        check("lh_data", rd_data_o, 32'hFFFF_9ABC);
        // timeout: gnt never asserted
        mem_req(0, 3'b010, 32'h500, 0, 3);
        tick();
        idle_in();
        check("to_req", bus_req_o, 1);
        check("to_hold", hold_flag_o, 1);
        n = 0;
        while (!bus_err_o && n < 20) begin
            tick();
            n++;
        end
        check("to_cycles", n, 8);
        check("to_hold_drop", hold_flag_o, 0);
        check("to_req_drop", bus_req_o, 0);
        check("to_wen", rd_wen_o, 0);
        alu_op(2, 32'h55);
        tick();
        check("to_pulse_end", bus_err_o, 0);
        check("add_data", rd_data_o, 32'h55);
        check("add_wen", rd_wen_o, 1);
        idle_in();
        // bus error on response
        mem_req(0, 3'b000, 32'h600, 0, 4);
        tick();
        idle_in(); bus_gnt_i = 1; bus_rvalid_i = 1; bus_err_i = 1;
        tick();
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0;
        check("berr_pulse", bus_err_o, 1);
        check("berr_wen", rd_wen_o, 0);
        // late rvalid in IDLE is ignored
        bus_rvalid_i = 1; bus_err_i = 1;
        tick();
        bus_rvalid_i = 0; bus_err_i = 0;
        check("late_rv", {bus_err_o, rd_wen_o, hold_flag_o}, 0);
        // reset mid-WAIT
        mem_req(0, 3'b010, 32'h700, 0, 8);
        tick();
        idle_in(); bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        check("wait_hold", hold_flag_o, 1);
        #2 rst_n = 0;
        #1 check("rst_wait_hold", hold_flag_o, 0);
        check("rst_wait_req", bus_req_o, 0);
        tick();
        rst_n = 1;
        // reset mid-REQ
        mem_req(0, 3'b010, 32'h704, 0, 8);
        tick();
        idle_in();
        check("req_before_rst", bus_req_o, 1);
        #2 rst_n = 0;
        #1 check("rst_req_req", bus_req_o, 0);
        check("rst_req_hold", hold_flag_o, 0);
        tick();
        rst_n = 1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
